// File: rtl/mmm_csa_reducer.sv
// rtl/mmm_csa_reducer.sv - carry-save resolve and restoring reduction stage (optional MMM_RAW_SUM_EN exposes sum_raw)
module mmm_csa_reducer #(
    parameter int W  = 4,
    parameter int SW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] S1,
    input  logic [SW-1:0] S2,
    input  logic [W-1:0]  N,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  R,
    output logic          err
`ifdef MMM_RAW_SUM_EN
    ,
    output logic [SW:0]   sum_raw
`endif
);

    localparam int RW = SW + W + 1;
    localparam int IW = $clog2(SW + 1);

    typedef enum logic [1:0] {IDLE, ADD, REDUCE, DONE} state_t;

    state_t          state_q;
    logic [SW-1:0]   s1_q, s2_q;
    logic [W-1:0]    n_q;
    logic            c_q;
    logic [IW-1:0]   idx_q;
    logic [SW:0]     sum_q;
    logic [RW-1:0]   rem_q;
    logic [W-1:0]    r_q;
    logic            err_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic            bit_d;
    logic            carry_d;
    logic [SW:0]     sum_d;
    logic [RW-1:0]   dvs;
    logic [RW-1:0]   rem_d;

    // idx_q is the bit index during ADD and the shift amount k during REDUCE.
    always_comb begin
        bit_d   = s1_q[idx_q] ^ s2_q[idx_q] ^ c_q;
        carry_d = (s1_q[idx_q] & s2_q[idx_q]) | (s1_q[idx_q] & c_q) | (s2_q[idx_q] & c_q);
        sum_d   = sum_q;
        sum_d[idx_q] = bit_d;
        if (idx_q == IW'(SW - 1)) begin
            sum_d[SW] = carry_d;
        end
        dvs   = RW'(n_q) << idx_q;
        rem_d = (rem_q >= dvs) ? (rem_q - dvs) : rem_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s1_q        <= '0;
            s2_q        <= '0;
            n_q         <= '0;
            c_q         <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            rem_q       <= '0;
            r_q         <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        s1_q       <= S1;
                        s2_q       <= S2;
                        n_q        <= N;
                        c_q        <= 1'b0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ADD;
                    end
                end
                ADD: begin
                    sum_q <= sum_d;
                    c_q   <= carry_d;
                    if (idx_q == IW'(SW - 1)) begin
                        if (n_q == '0) begin
                            r_q         <= '0;
                            err_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            rem_q   <= RW'(sum_d);
                            idx_q   <= IW'(SW);
                            state_q <= REDUCE;
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                REDUCE: begin
                    rem_q <= rem_d;
                    if (idx_q == '0) begin
                        r_q         <= rem_d[W-1:0];
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign R         = r_q;
    assign err       = err_q;
`ifdef MMM_RAW_SUM_EN
    // sum_q is untouched after ADD, so it stays stable through DONE.
    assign sum_raw   = sum_q;
`endif

endmodule

// File: tb/tb_mmm_csa_reducer.sv
// tb/tb_mmm_csa_reducer.sv - scoreboard bench for mmm_csa_reducer
module tb_mmm_csa_reducer;

    localparam int W  = 4;
    localparam int SW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] S1, S2;
    logic [W-1:0]  N;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  R;
    logic          err;
`ifdef MMM_RAW_SUM_EN
    logic [SW:0]   sum_raw;
`endif

    mmm_csa_reducer #(.W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S1        (S1),
        .S2        (S2),
        .N         (N),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .err       (err)
`ifdef MMM_RAW_SUM_EN
        ,
        .sum_raw   (sum_raw)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int e;
        int lat;
        int sum;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic accept(input int s1, input int s2, input int n);
        exp_t x;
        @(negedge clk);
        S1 = SW'(s1);
        S2 = SW'(s2);
        N  = W'(n);
        in_valid = 1'b1;
        chk("in_ready_idle", int'(in_ready), 1);
        @(posedge clk);
        x.sum = s1 + s2;
        x.e   = (n == 0) ? 1 : 0;
        x.r   = (n == 0) ? 0 : (x.sum % n);
        x.lat = (n == 0) ? SW : (2 * SW + 1);
        sb.push_back(x);
        #1;
        in_valid = 1'b0;
        S1 = SW'($urandom);
        S2 = SW'($urandom);
        N  = W'($urandom);
    endtask

    task automatic finish_txn(input int stall);
        exp_t x;
        int   cnt;
        int   busy_bad;
        int   hold_bad;
        logic [W-1:0] r0;
        logic e0;
        cnt = 0;
        busy_bad = 0;
        while (cnt < 40) begin
            @(posedge clk);
            cnt++;
            #1;
            if (out_valid) break;
            if (in_ready) busy_bad++;
            in_valid = 1'b1;
        end
        in_valid = 1'b0;
        x = sb.pop_front();
        chk("latency", cnt, x.lat);
        chk("in_ready_busy", busy_bad, 0);
        chk("R", int'(R), x.r);
        chk("err", int'(err), x.e);
`ifdef MMM_RAW_SUM_EN
        chk("sum_raw", int'(sum_raw), x.sum);
`endif
        r0 = R;
        e0 = err;
        hold_bad = 0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || R !== r0 || err !== e0) hold_bad++;
        end
        if (stall > 0) chk("stall_hold", hold_bad, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_drop", int'(out_valid), 0);
        chk("in_ready_back", int'(in_ready), 1);
    endtask

    task automatic reset_mid(input int cycles);
        exp_t x;
        accept(12, 10, 15);
        repeat (cycles) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_R", int'(R), 0);
        chk("rst_err", int'(err), 0);
        x = sb.pop_front();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        S1 = '0;
        S2 = '0;
        N = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_R", int'(R), 0);
        chk("reset_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        accept(5, 3, 11);     finish_txn(0);
        accept(127, 127, 13); finish_txn(0);
        accept(12, 10, 1);    finish_txn(0);
        accept(12, 10, 15);   finish_txn(0);
        accept(16, 1, 0);     finish_txn(0);
        accept(100, 27, 9);   finish_txn(5);
        accept(127, 127, 0);  finish_txn(2);

        reset_mid(3);
        accept(7, 9, 5);      finish_txn(0);
        reset_mid(10);
        accept(127, 1, 14);   finish_txn(0);

        for (int t = 0; t < 12; t++) begin
            accept(int'($urandom_range(127)), int'($urandom_range(127)), int'($urandom_range(15)));
            finish_txn(int'($urandom_range(2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmm_csa_reducer.md
Name: mmm_csa_reducer

Overview:
- Downstream stage of the radix-4 Montgomery multiplier.
- Consumes the multiplier's redundant carry-save result pair (S1, S2) together with the modulus N.
- Resolves the pair with a bit-serial carry-propagate add, then does a restoring shift-subtract reduction, producing a fully reduced binary residue in [0, N).
- Valid/ready handshake on both sides, so it can be chained behind the multiplier and ahead of any consumer.

Parameters:
- W, 4, operand/modulus width; also the width of the result.
- SW, 7, width of each carry-save input word. The raw sum is SW+1 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  S1/S2/N are valid.
- in_ready  out  1  block can accept an input.
- S1  in  SW  carry-save sum word.
- S2  in  SW  carry-save carry word.
- N  in  W  modulus.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- R  out  W  reduced residue, equal to (S1+S2) mod N.
- err  out  1  N was zero for this transaction.

Behaviour:
- Reset: asynchronous and active-low, as decided above. Asserting rst_n low at any time, including mid-operation, forces:
  - state IDLE;
  - in_ready=1, out_valid=0, R=0, err=0;
  - all internal registers cleared.
  - No partial result is ever emitted after reset.
- States: IDLE, ADD, REDUCE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, at that clock edge (the accept edge E0): latch S1, S2 and N, clear the carry register, clear the bit index, go to ADD.
- ADD:
  - One bit per cycle: sum[i] = s1[i] ^ s2[i] ^ c, and c <= majority(s1[i], s2[i], c), for i = 0..SW-1.
  - After bit SW-1, sum[SW] = final carry.
  - Takes SW edges (E1..E7 at the defaults).
  - If the latched N == 0: go to DONE with err=1 and R=0.
  - Otherwise: go to REDUCE with k = SW.
- REDUCE:
  - Restoring step per cycle, evaluated in SW+W+1-bit arithmetic: if rem >= (N << k) then rem <= rem - (N << k).
  - k counts down from SW to 0, giving SW+1 edges (E8..E15 at the defaults).
  - After k = 0: R <= rem[W-1:0], err <= 0, go to DONE.
- DONE:
  - out_valid=1; R and err are held stable while out_ready=0.
  - On out_ready=1: go to IDLE and drop out_valid in the following cycle.
- in_ready is high only in IDLE. Inputs presented outside IDLE are ignored. Input values may change after E0 without effect.
- Latency from E0 to out_valid high:
  - N != 0: SW + SW + 1 edges, i.e. 15 at the defaults.
  - N == 0: SW edges, i.e. 7.
  - Fixed latency, independent of the data.
- Throughput: one transaction per (latency + 1 + consumer stall) cycles. There is no overlap of transactions.
- Width rules:
  - Sum range is 0..2*(2^SW - 1), i.e. 0..254 at the defaults. It must never overflow SW+1 bits.
  - R < N is guaranteed for every N >= 1.
  - The all-ones inputs S1 = S2 = 2^SW - 1 must be handled.

Optional Feature:
- Macro: MMM_RAW_SUM_EN.
- Defined:
  - Extra output port sum_raw, direction out, width SW+1. It carries the carry-propagated sum before reduction.
  - sum_raw is valid with out_valid, held in DONE, and reset to 0.
  - It is also driven on the N == 0 path.
- Undefined: the port and its register do not exist. All other behaviour is identical.

Test Plan:
- S1=7'h05, S2=7'h03, N=4'hB → out_valid 15 cycles after E0; R=4'h8; err=0 (sum_raw=8'h08 when MMM_RAW_SUM_EN is defined).
- S1=7'h7F, S2=7'h7F, N=4'hD (full-scale sum 254) → R=4'h7, err=0; sum_raw=8'hFE.
- S1=7'h0C, S2=7'h0A, N=4'h1, then on the next transaction N=4'hF → first R=0; second R=22 mod 15 = 4'h7. in_ready stays 0 throughout each transaction.
- N=4'h0, S1=7'h10, S2=7'h01 → err=1, R=0, out_valid 7 cycles after E0.
- Backpressure: complete a transaction with out_ready=0 for 5 cycles → R/err stable and in_ready=0 for those cycles. Raise out_ready → out_valid drops on the next cycle and in_ready returns to 1.
- Reset mid-operation: drop rst_n during ADD and separately during REDUCE → outputs clear immediately (asynchronously). A fresh transaction started after release gives the correct result, with no stale out_valid.
